// File: rtl/board_entry_if.sv
// Memory write handshake between the board entry block and data memory.
interface board_entry_if;
    logic        wr_req;
    logic [39:0] wr_addr;
    logic [39:0] wr_data;
    logic        wr_ack;

    modport master (output wr_req, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_req, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/board_entry.sv
// 8-puzzle start-board entry: debounced buttons edit 9 tiles, the board is checked
// to be a permutation of 0..8 and then written to data memory via req/ack.
module board_entry #(
    parameter int unsigned DEB_CYCLES = 20000,
    parameter logic [39:0] BASE_ADDR  = 40'd0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 btn_inc,
    input  logic                 btn_next,
    board_entry_if.master        mem,
    output logic [3:0]           cur_pos,
    output logic [3:0]           cur_val,
    output logic                 board_valid,
    output logic                 err
);
    localparam int unsigned CNT_W     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int unsigned TILE_W    = 4;
    localparam int unsigned NUM_TILES = 9;
    localparam int unsigned DATA_W    = 40;
    localparam int unsigned PAD_W     = DATA_W - NUM_TILES * TILE_W;

    typedef enum logic [2:0] {
        S_EDIT  = 3'd0,
        S_CHECK = 3'd1,
        S_SEND  = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Index 0 = inc button, index 1 = next button
    logic [1:0]            raw;
    logic [1:0]            sync1;
    logic [1:0]            sync2;
    logic [1:0]            lvl;
    logic [1:0]            pulse;
    logic [1:0][CNT_W-1:0] cnt;
    logic                  inc_p;
    logic                  next_p;

    assign raw    = {btn_next, btn_inc};
    assign inc_p  = pulse[0];
    assign next_p = pulse[1];

    // Synchronize, then accept a level change only after DEB_CYCLES stable samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            lvl   <= '0;
            pulse <= '0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int b = 0; b < 2; b++) begin
                pulse[b] <= 1'b0;
                if (sync2[b] == lvl[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_W'(DEB_CYCLES - 1)) begin
                    lvl[b]   <= sync2[b];
                    cnt[b]   <= '0;
                    pulse[b] <= sync2[b];
                end else begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    state_t                            state_q;
    state_t                            state_n;
    logic [NUM_TILES-1:0][TILE_W-1:0]  tile_q;
    logic [NUM_TILES-1:0][TILE_W-1:0]  tile_n;
    logic [3:0]                        pos_n;
    logic [3:0]                        val_n;
    logic [NUM_TILES-1:0]              mask;

    // Seen mask: values above 8 shift out and leave the mask incomplete
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            mask = mask | (NUM_TILES'(1) << tile_q[i]);
        end
    end

    always_comb begin
        state_n = state_q;
        pos_n   = cur_pos;
        val_n   = cur_val;
        tile_n  = tile_q;
        case (state_q)
            S_EDIT: begin
                if (next_p) begin
                    tile_n[cur_pos] = cur_val;
                    val_n           = '0;
                    if (cur_pos == 4'(NUM_TILES - 1)) begin
                        state_n = S_CHECK;
                    end else begin
                        pos_n = cur_pos + 4'(1);
                    end
                end else if (inc_p) begin
                    val_n = (cur_val == 4'(8)) ? 4'(0) : cur_val + 4'(1);
                end
            end
            S_CHECK: state_n = (mask == {NUM_TILES{1'b1}}) ? S_SEND : S_ERR;
            S_SEND: begin
                if (mem.wr_ack) begin
                    state_n = S_DONE;
                end
            end
            S_DONE, S_ERR: begin
                if (next_p) begin
                    state_n = S_EDIT;
                    pos_n   = '0;
                    val_n   = '0;
                    tile_n  = '0;
                end
            end
            default: begin
                state_n = S_EDIT;
                pos_n   = '0;
                val_n   = '0;
                tile_n  = '0;
            end
        endcase
    end

    // All outputs registered from next-state values so they align with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EDIT;
            cur_pos     <= '0;
            cur_val     <= '0;
            tile_q      <= '0;
            mem.wr_req  <= 1'b0;
            mem.wr_addr <= '0;
            mem.wr_data <= '0;
            board_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_n;
            cur_pos     <= pos_n;
            cur_val     <= val_n;
            tile_q      <= tile_n;
            mem.wr_req  <= (state_n == S_SEND);
            mem.wr_addr <= (state_n == S_SEND) ? BASE_ADDR : '0;
            mem.wr_data <= (state_n == S_SEND) ? {PAD_W'(0), tile_n} : '0;
            board_valid <= (state_n == S_DONE);
            err         <= (state_n == S_ERR);
        end
    end
endmodule

// File: tb/tb_board_entry.sv
// Directed bench for board_entry: scoreboarded button presses and memory writes.
module tb_board_entry;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = DEB + 6;
    localparam logic [39:0] BASE = 40'h12_3456_789A;

    logic clk;
    logic rst_n;
    logic btn_inc;
    logic btn_next;
    logic [3:0] cur_pos;
    logic [3:0] cur_val;
    logic board_valid;
    logic err;

    board_entry_if mem_if ();

    board_entry #(.DEB_CYCLES(DEB), .BASE_ADDR(BASE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_inc     (btn_inc),
        .btn_next    (btn_next),
        .mem         (mem_if.master),
        .cur_pos     (cur_pos),
        .cur_val     (cur_val),
        .board_valid (board_valid),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int req_cycles = 0;

    always @(posedge clk) begin
        if (mem_if.wr_req) req_cycles <= req_cycles + 1;
    end

    typedef struct packed {
        logic [3:0] pos;
        logic [3:0] val;
    } ui_t;

    ui_t         ui_q[$];
    logic [39:0] wr_q[$];

    // Reference model of the editing state
    logic [3:0] m_pos;
    logic [3:0] m_val;
    logic [8:0][3:0] m_tile;
    bit         m_edit;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos  = '0;
        m_val  = '0;
        m_tile = '0;
        m_edit = 1'b1;
        ui_q.delete();
        wr_q.delete();
    endtask

    task automatic model_press(input logic inc, input logic nxt);
        logic [8:0] seen;
        if (m_edit) begin
            if (nxt) begin
                m_tile[m_pos] = m_val;
                m_val = '0;
                if (m_pos == 4'd8) begin
                    m_edit = 1'b0;
                    seen = '0;
                    for (int i = 0; i < 9; i++) seen[m_tile[i]] = 1'b1;
                    if (seen == 9'h1FF) wr_q.push_back({4'h0, m_tile});
                end else begin
                    m_pos = m_pos + 4'd1;
                end
            end else if (inc) begin
                m_val = (m_val == 4'd8) ? 4'd0 : m_val + 4'd1;
            end
        end else if (nxt) begin
            m_pos  = '0;
            m_val  = '0;
            m_tile = '0;
            m_edit = 1'b1;
        end
        ui_q.push_back('{pos: m_pos, val: m_val});
    endtask

    task automatic compare_ui(input string tag);
        ui_t e;
        if (ui_q.size() == 0) begin
            check({tag, "_queue_empty"}, 40'd1, 40'd0);
        end else begin
            e = ui_q.pop_front();
            check({tag, "_pos"}, 40'(cur_pos), 40'(e.pos));
            check({tag, "_val"}, 40'(cur_val), 40'(e.val));
        end
    endtask

    task automatic press(input logic inc, input logic nxt);
        model_press(inc, nxt);
        @(negedge clk);
        btn_inc  = inc;
        btn_next = nxt;
        repeat (HOLD) @(negedge clk);
        btn_inc  = 1'b0;
        btn_next = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic press_chk(input logic inc, input logic nxt, input string tag);
        press(inc, nxt);
        compare_ui(tag);
    endtask

    task automatic enter_board(input logic [35:0] b);
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < int'(b[4*i +: 4]); k++) press_chk(1'b1, 1'b0, "enter_inc");
            press_chk(1'b0, 1'b1, "enter_next");
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (mem_if.wr_req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        bit          ok;
        logic [39:0] exp_d;
        int          req_before;

        rst_n = 1'b0;
        btn_inc = 1'b0;
        btn_next = 1'b0;
        mem_if.wr_ack = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_pos", 40'(cur_pos), 40'd0);
        check("rst_val", 40'(cur_val), 40'd0);
        check("rst_req", 40'(mem_if.wr_req), 40'd0);
        check("rst_addr", mem_if.wr_addr, 40'd0);
        check("rst_data", mem_if.wr_data, 40'd0);
        check("rst_valid", 40'(board_valid), 40'd0);
        check("rst_err", 40'(err), 40'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Bouncing contact: toggling every 2 clk never settles, then a steady press
        model_press(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            btn_inc = ~btn_inc;
            repeat (2) @(negedge clk);
        end
        check("bounce_no_pulse", 40'(cur_val), 40'd0);
        btn_inc = 1'b1;
        repeat (HOLD) @(negedge clk);
        btn_inc = 1'b0;
        repeat (HOLD) @(negedge clk);
        compare_ui("bounce");

        // Value wraps 8 -> 0
        apply_reset();
        for (int k = 0; k < 9; k++) press_chk(1'b1, 1'b0, "wrap");

        // Simultaneous inc and next: next wins
        for (int k = 0; k < 3; k++) press_chk(1'b1, 1'b0, "sim_inc");
        press_chk(1'b1, 1'b1, "sim_both");
        check("sim_tile0", 40'(dut.tile_q[0]), 40'd3);

        // Valid permutation written to memory
        apply_reset();
        enter_board({4'd0, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1});
        wait_req(ok);
        check("send_req", 40'(ok), 40'd1);
        if (wr_q.size() == 0) check("send_queue_empty", 40'd1, 40'd0);
        else begin
            exp_d = wr_q.pop_front();
            check("send_data", mem_if.wr_data, exp_d);
            check("send_data_const", mem_if.wr_data, 40'h00_8765_4321);
        end
        check("send_addr", mem_if.wr_addr, BASE);
        repeat (3) @(negedge clk);
        check("send_hold_req", 40'(mem_if.wr_req), 40'd1);
        check("send_hold_data", mem_if.wr_data, 40'h00_8765_4321);
        mem_if.wr_ack = 1'b1;
        @(negedge clk);
        mem_if.wr_ack = 1'b0;
        check("ack_req_low", 40'(mem_if.wr_req), 40'd0);
        check("ack_data_zero", mem_if.wr_data, 40'd0);
        check("done_valid", 40'(board_valid), 40'd1);
        press_chk(1'b1, 1'b0, "done_inc_ignored");
        check("done_valid_hold", 40'(board_valid), 40'd1);
        press_chk(1'b0, 1'b1, "done_restart");
        check("restart_valid", 40'(board_valid), 40'd0);

        // Duplicate values -> error, no write
        apply_reset();
        req_before = req_cycles;
        enter_board({4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd1});
        check("dup_err", 40'(err), 40'd1);
        check("dup_valid", 40'(board_valid), 40'd0);
        check("dup_no_req", 40'(req_cycles - req_before), 40'd0);
        check("dup_no_write_expected", 40'(wr_q.size()), 40'd0);
        press_chk(1'b0, 1'b1, "err_restart");
        check("err_cleared", 40'(err), 40'd0);

        // Asynchronous reset while a write is outstanding
        apply_reset();
        enter_board({4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8});
        wait_req(ok);
        check("rst_send_req", 40'(ok), 40'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_req_drop", 40'(mem_if.wr_req), 40'd0);
        check("async_pos", 40'(cur_pos), 40'd0);
        check("async_tiles", 40'(dut.tile_q), 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        press_chk(1'b1, 1'b0, "post_rst_edit");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
